// File: rtl/hazard_pkg.sv
// Shared constants and helpers for the register hazard scoreboard.
`timescale 1ns/1ps
package hazard_pkg;

    localparam int LAT_W_DEF  = 3;
    localparam int BR_PEN_DEF = 1;

    // All-ones countdown value marks a result of unknown latency.
    localparam logic [LAT_W_DEF-1:0] UNK = '1;

    function automatic logic mispredict(input logic resolve, input logic taken, input logic pred);
        return resolve & (taken ^ pred);
    endfunction

endpackage

// File: rtl/hz_sb_entry.sv
// One scoreboard counter: cycles until a pending result becomes usable by an EX consumer.
`timescale 1ns/1ps
module hz_sb_entry #(
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    input  logic             clear,
    input  logic             hold,
    output logic [LAT_W-1:0] cnt
);

    localparam logic [LAT_W-1:0] LAT_UNK = '1;

    // A new writer wins over writeback; UNK stays until writeback clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (clear) begin
            cnt <= '0;
        end else if (!hold && cnt != '0 && cnt != LAT_UNK) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: stall/issue/flush decisions for the ID stage.
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall-cycle and flush counters.
`timescale 1ns/1ps
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = 5,
    parameter int LAT_W    = LAT_W_DEF,
    parameter int BR_PEN   = BR_PEN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_branch,
    input  logic              id_wr,
    input  logic [REG_AW-1:0] id_dst,
    input  logic [LAT_W-1:0]  id_lat,
    input  logic              ex_hold,
    input  logic              wb_done,
    input  logic [REG_AW-1:0] wb_dst,
    input  logic              br_resolve,
    input  logic              br_taken,
    input  logic              br_pred,
    input  logic              jump,
    output logic              stall,
    output logic              issue,
    output logic              flush,
    output logic              cpc
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]       perf_stall_cyc,
    output logic [31:0]       perf_flush_cnt
`endif
);

    localparam logic [LAT_W-1:0] LAT_UNK = '1;
    localparam logic [LAT_W-1:0] PEN_V   = LAT_W'(BR_PEN);

    logic [LAT_W-1:0] cnt [NUM_REGS];
    logic [LAT_W-1:0] load_val;
    logic             mis;
    logic             haz;
    int               lat_sum;

    // Branches compare in ID, so they wait for a fully drained counter.
    function automatic logic src_hazard(input logic use_s, input logic [REG_AW-1:0] s,
                                        input logic [LAT_W-1:0] c, input logic br);
        if (!use_s || s == '0) return 1'b0;
        return br ? (c != '0) : (c > PEN_V);
    endfunction

    always_comb begin
        mis   = mispredict(br_resolve, br_taken, br_pred);
        flush = (mis | jump) & ~rst;
        cpc   = mis & ~rst;
        haz   = src_hazard(id_use_rs, id_rs, cnt[id_rs], id_branch)
              | src_hazard(id_use_rt, id_rt, cnt[id_rt], id_branch);
        stall = id_valid & (haz | ex_hold) & ~flush & ~rst;
        issue = id_valid & ~stall & ~flush & ~rst;
    end

    // Known latencies are biased by the branch penalty and clipped below UNK.
    always_comb begin
        load_val = '0;
        lat_sum  = int'(id_lat) + BR_PEN;
        if (id_lat == LAT_UNK) begin
            load_val = LAT_UNK;
        end else if (lat_sum >= int'(LAT_UNK)) begin
            load_val = LAT_UNK - 1'b1;
        end else begin
            load_val = LAT_W'(lat_sum);
        end
    end

    assign cnt[0] = '0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        hz_sb_entry #(
            .LAT_W(LAT_W)
        ) u_entry (
            .clk     (clk),
            .rst     (rst),
            .load    (issue & id_wr & (id_dst == REG_AW'(r))),
            .load_val(load_val),
            .clear   (wb_done & (wb_dst == REG_AW'(r))),
            .hold    (ex_hold),
            .cnt     (cnt[r])
        );
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cyc <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall && !ex_hold && perf_stall_cyc != '1) perf_stall_cyc <= perf_stall_cyc + 1'b1;
            if (flush && perf_flush_cnt != '1) perf_flush_cnt <= perf_flush_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus random traffic vs. a reference model.
// Perf counter checks are compiled in when HAZARD_PERF_CNT_EN is defined.
`timescale 1ns/1ps
module tb_hazard_scoreboard;

    localparam int NUM_REGS = 32;
    localparam int REG_AW   = 5;
    localparam int LAT_W    = 3;
    localparam int BR_PEN   = 1;
    localparam int UNK      = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid, id_use_rs, id_use_rt, id_branch, id_wr;
    logic [REG_AW-1:0] id_rs, id_rt, id_dst, wb_dst;
    logic [LAT_W-1:0]  id_lat;
    logic              ex_hold, wb_done, br_resolve, br_taken, br_pred, jump;
    logic              stall, issue, flush, cpc;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]       perf_stall_cyc, perf_flush_cnt;
`endif

    hazard_scoreboard #(
        .NUM_REGS(NUM_REGS), .REG_AW(REG_AW), .LAT_W(LAT_W), .BR_PEN(BR_PEN)
    ) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_branch(id_branch),
        .id_wr(id_wr), .id_dst(id_dst), .id_lat(id_lat),
        .ex_hold(ex_hold), .wb_done(wb_done), .wb_dst(wb_dst),
        .br_resolve(br_resolve), .br_taken(br_taken), .br_pred(br_pred), .jump(jump),
        .stall(stall), .issue(issue), .flush(flush), .cpc(cpc)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: cycles remaining per register, plus perf totals.
    int   mcnt [NUM_REGS];
    int   m_perf_stall = 0;
    int   m_perf_flush = 0;
    logic exp_stall, exp_issue, exp_flush, exp_cpc;
    logic obs_stall, obs_issue, obs_flush, obs_cpc;

    function automatic void model_clear();
        for (int i = 0; i < NUM_REGS; i++) mcnt[i] = 0;
        m_perf_stall = 0;
        m_perf_flush = 0;
    endfunction

    function automatic logic src_blocks(input logic use_s, input int s, input logic br);
        if (!use_s || s == 0) return 1'b0;
        if (br) return mcnt[s] != 0;
        return mcnt[s] > BR_PEN;
    endfunction

    function automatic void model_eval();
        logic mis, fl, haz;
        mis = br_resolve && (br_taken != br_pred);
        fl  = mis || jump;
        haz = src_blocks(id_use_rs, int'(id_rs), id_branch) || src_blocks(id_use_rt, int'(id_rt), id_branch);
        exp_flush = fl;
        exp_cpc   = mis;
        exp_stall = id_valid && (haz || ex_hold) && !fl;
        exp_issue = id_valid && !exp_stall && !fl;
    endfunction

    function automatic void model_advance();
        int lat;
        for (int r = 1; r < NUM_REGS; r++) begin
            lat = int'(id_lat);
            if (exp_issue && id_wr && int'(id_dst) == r) begin
                if (lat == UNK) mcnt[r] = UNK;
                else if (lat + BR_PEN > UNK - 1) mcnt[r] = UNK - 1;
                else mcnt[r] = lat + BR_PEN;
            end else if (wb_done && int'(wb_dst) == r) begin
                mcnt[r] = 0;
            end else if (!ex_hold && mcnt[r] != 0 && mcnt[r] != UNK) begin
                mcnt[r] = mcnt[r] - 1;
            end
        end
        if (exp_stall && !ex_hold) m_perf_stall++;
        if (exp_flush) m_perf_flush++;
    endfunction

    task automatic clear_inputs();
        id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; id_branch = 0;
        id_wr = 0; id_dst = 0; id_lat = 0; ex_hold = 0; wb_done = 0; wb_dst = 0;
        br_resolve = 0; br_taken = 0; br_pred = 0; jump = 0;
    endtask

    // Called with clk low: samples outputs, advances the model, returns after the next negedge.
    task automatic step();
        #1;
        obs_stall = stall; obs_issue = issue; obs_flush = flush; obs_cpc = cpc;
        model_eval();
        model_advance();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1; id_valid = 1; jump = 1; br_resolve = 1; br_taken = 1; ex_hold = 1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
        n_checks++; if (issue !== 1'b0) begin n_fail++; $display("FAIL reset_issue: got %b expected 0", issue); end
        n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b expected 0", flush); end
        n_checks++; if (cpc !== 1'b0) begin n_fail++; $display("FAIL reset_cpc: got %b expected 0", cpc); end
`ifdef HAZARD_PERF_CNT_EN
        n_checks++; if (perf_stall_cyc !== 32'd0) begin n_fail++; $display("FAIL reset_perf_stall: got %0d expected 0", perf_stall_cyc); end
        n_checks++; if (perf_flush_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_perf_flush: got %0d expected 0", perf_flush_cnt); end
`endif
        clear_inputs();
        rst = 0;
        model_clear();
        @(negedge clk);
    endtask

    task automatic test_load_use();
        clear_inputs(); id_valid = 1; id_wr = 1; id_dst = 8; id_lat = 1;
        step();
        n_checks++; if (obs_issue !== 1'b1) begin n_fail++; $display("FAIL load_use_lw_issue: got %b expected 1", obs_issue); end
        clear_inputs(); id_valid = 1; id_rs = 8; id_use_rs = 1; id_wr = 1; id_dst = 10;
        step();
        n_checks++; if (obs_stall !== 1'b1 || obs_issue !== 1'b0)
            begin n_fail++; $display("FAIL load_use_stall: stall/issue %b%b expected 10", obs_stall, obs_issue); end
        step();
        n_checks++; if (obs_stall !== 1'b0 || obs_issue !== 1'b1)
            begin n_fail++; $display("FAIL load_use_issue: stall/issue %b%b expected 01", obs_stall, obs_issue); end
        clear_inputs(); repeat (4) step();
    endtask

    task automatic test_branch_use();
        clear_inputs(); id_valid = 1; id_wr = 1; id_dst = 8; id_lat = 1;
        step();
        clear_inputs(); id_valid = 1; id_branch = 1; id_rs = 8; id_use_rs = 1; id_rt = 0; id_use_rt = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (obs_stall !== (i < 2) || obs_issue !== (i == 2))
                begin n_fail++; $display("FAIL branch_use_c%0d: stall/issue %b%b expected %b%b", i, obs_stall, obs_issue, i < 2, i == 2); end
        end
        clear_inputs(); repeat (3) step();
    endtask

    task automatic test_unknown_latency();
        int k;
        k = $urandom_range(2, 6);
        clear_inputs(); id_valid = 1; id_wr = 1; id_dst = 9; id_lat = 3'(UNK);
        step();
        clear_inputs(); id_valid = 1; id_rt = 9; id_use_rt = 1;
        for (int i = 0; i < k; i++) begin
            step();
            n_checks++; if (obs_stall !== 1'b1) begin n_fail++; $display("FAIL unk_wait_c%0d: stall got %b expected 1", i, obs_stall); end
        end
        wb_done = 1; wb_dst = 9;
        step();
        n_checks++; if (obs_stall !== 1'b1) begin n_fail++; $display("FAIL unk_wb_cycle: stall got %b expected 1", obs_stall); end
        wb_done = 0; wb_dst = 0;
        step();
        n_checks++; if (obs_issue !== 1'b1) begin n_fail++; $display("FAIL unk_after_wb: issue got %b expected 1", obs_issue); end
        clear_inputs(); step();
    endtask

    task automatic test_mispredict();
        clear_inputs(); id_valid = 1; id_wr = 1; id_dst = 5; id_lat = 2;
        br_resolve = 1; br_taken = 1; br_pred = 0;
        step();
        n_checks++; if ({obs_flush, obs_cpc, obs_issue, obs_stall} !== 4'b1100)
            begin n_fail++; $display("FAIL mispredict: flush/cpc/issue/stall %b%b%b%b expected 1100", obs_flush, obs_cpc, obs_issue, obs_stall); end
        clear_inputs(); id_valid = 1; id_branch = 1; id_rs = 5; id_use_rs = 1;
        step();
        n_checks++; if (obs_issue !== 1'b1) begin n_fail++; $display("FAIL mispredict_no_load: issue got %b expected 1", obs_issue); end
        clear_inputs(); id_valid = 1; jump = 1; br_resolve = 1; br_taken = 1; br_pred = 1;
        step();
        n_checks++; if ({obs_flush, obs_cpc, obs_issue} !== 3'b100)
            begin n_fail++; $display("FAIL jump_flush: flush/cpc/issue %b%b%b expected 100", obs_flush, obs_cpc, obs_issue); end
        clear_inputs(); step();
    endtask

    task automatic test_ex_hold();
        clear_inputs(); id_valid = 1; id_wr = 1; id_dst = 8; id_lat = 1;
        step();
        clear_inputs(); id_valid = 1; id_rs = 8; id_use_rs = 1; ex_hold = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (obs_stall !== 1'b1 || obs_issue !== 1'b0)
                begin n_fail++; $display("FAIL hold_c%0d: stall/issue %b%b expected 10", i, obs_stall, obs_issue); end
        end
        ex_hold = 0;
        step();
        n_checks++; if (obs_stall !== 1'b1) begin n_fail++; $display("FAIL hold_cnt_kept: stall got %b expected 1", obs_stall); end
        step();
        n_checks++; if (obs_issue !== 1'b1) begin n_fail++; $display("FAIL hold_resume: issue got %b expected 1", obs_issue); end
        clear_inputs(); repeat (2) step();
    endtask

    task automatic test_load_wins();
        clear_inputs(); id_valid = 1; id_wr = 1; id_dst = 9; id_lat = 2; wb_done = 1; wb_dst = 9;
        step();
        clear_inputs(); id_valid = 1; id_branch = 1; id_rt = 9; id_use_rt = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++; if (obs_stall !== (i < 3))
                begin n_fail++; $display("FAIL load_wins_c%0d: stall got %b expected %b", i, obs_stall, i < 3); end
        end
        clear_inputs(); id_valid = 1; id_wr = 1; id_dst = 10; id_lat = 6;
        step();
        clear_inputs(); id_valid = 1; id_branch = 1; id_rs = 10; id_use_rs = 1;
        for (int i = 0; i < 7; i++) begin
            step();
            n_checks++; if (obs_stall !== (i < 6))
                begin n_fail++; $display("FAIL lat_clip_c%0d: stall got %b expected %b", i, obs_stall, i < 6); end
        end
        clear_inputs(); step();
    endtask

    task automatic test_reset_mid();
        clear_inputs(); id_valid = 1; id_wr = 1; id_dst = 9; id_lat = 3'(UNK);
        step();
        clear_inputs(); id_valid = 1; id_rs = 9; id_use_rs = 1; jump = 0;
        step();
        rst = 1; jump = 1;
        #1;
        n_checks++; if ({stall, issue, flush, cpc} !== 4'b0000)
            begin n_fail++; $display("FAIL reset_mid_outputs: stall/issue/flush/cpc %b%b%b%b expected 0000", stall, issue, flush, cpc); end
        @(posedge clk); @(negedge clk);
        rst = 0; jump = 0;
        model_clear();
        step();
        n_checks++; if (obs_issue !== 1'b1) begin n_fail++; $display("FAIL reset_mid_empty: issue got %b expected 1", obs_issue); end
        clear_inputs(); step();
    endtask

    task automatic test_random();
        logic [REG_AW-1:0] pool [6];
        pool[0] = 0; pool[1] = 1; pool[2] = 2; pool[3] = 3; pool[4] = 8; pool[5] = 9;
        for (int c = 0; c < 1500; c++) begin
            id_valid   = ($urandom_range(0, 9) < 8);
            id_rs      = pool[$urandom_range(0, 5)];
            id_rt      = pool[$urandom_range(0, 5)];
            id_use_rs  = $urandom_range(0, 1);
            id_use_rt  = $urandom_range(0, 1);
            id_branch  = ($urandom_range(0, 4) == 0);
            id_wr      = $urandom_range(0, 1);
            id_dst     = pool[$urandom_range(0, 5)];
            id_lat     = 3'($urandom_range(0, 7));
            ex_hold    = ($urandom_range(0, 4) == 0);
            wb_done    = ($urandom_range(0, 5) == 0);
            wb_dst     = pool[$urandom_range(0, 5)];
            br_resolve = ($urandom_range(0, 4) == 0);
            br_taken   = $urandom_range(0, 1);
            br_pred    = $urandom_range(0, 1);
            jump       = ($urandom_range(0, 19) == 0);
            step();
            n_checks++;
            if ({obs_stall, obs_issue, obs_flush, obs_cpc} !== {exp_stall, exp_issue, exp_flush, exp_cpc})
                begin n_fail++; $display("FAIL random_c%0d: stall/issue/flush/cpc %b%b%b%b expected %b%b%b%b", c,
                    obs_stall, obs_issue, obs_flush, obs_cpc, exp_stall, exp_issue, exp_flush, exp_cpc); end
        end
        clear_inputs(); step();
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf();
        n_checks++; if (perf_stall_cyc !== 32'(m_perf_stall))
            begin n_fail++; $display("FAIL perf_stall_cyc: got %0d expected %0d", perf_stall_cyc, m_perf_stall); end
        n_checks++; if (perf_flush_cnt !== 32'(m_perf_flush))
            begin n_fail++; $display("FAIL perf_flush_cnt: got %0d expected %0d", perf_flush_cnt, m_perf_flush); end
    endtask
`endif

    initial begin
        test_reset();
        test_load_use();
        test_branch_use();
        test_unknown_latency();
        test_mispredict();
        test_ex_hold();
        test_load_wins();
        test_reset_mid();
        test_random();
`ifdef HAZARD_PERF_CNT_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NUM_REGS, default 32: architectural register count; register 0 is hardwired zero.
REQ-002 Parameter REG_AW, default 5: register address width, clog2(NUM_REGS).
REQ-003 Parameter LAT_W, default 3: per-register countdown width; value 2^LAT_W-1 (UNK) means unknown latency.
REQ-004 Parameter BR_PEN, default 1: extra cycles a branch in ID needs beyond an EX consumer.
REQ-005 clk  in  1  single clock; all state rises on posedge clk.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 id_valid  in  1  instruction present in ID.
REQ-008 id_rs, id_rt  in  REG_AW  source registers; id_use_rs, id_use_rt  in  1  source actually read.
REQ-009 id_branch  in  1  ID instruction is a branch that compares operands in ID.
REQ-010 id_wr, id_dst  in  1, REG_AW  ID instruction writes id_dst.
REQ-011 id_lat  in  LAT_W  cycles until the result is forwardable to an EX consumer; UNK means variable latency.
REQ-012 ex_hold  in  1  downstream pipeline frozen this cycle.
REQ-013 wb_done, wb_dst  in  1, REG_AW  variable-latency result written back.
REQ-014 br_resolve, br_taken, br_pred  in  1  branch resolved in EX, actual outcome, prediction.
REQ-015 jump  in  1  unconditional redirect.
REQ-016 stall  out  1  hold PC and IF/ID.
REQ-017 issue  out  1  ID instruction advances this cycle.
REQ-018 flush  out  1  squash IF/ID.
REQ-019 cpc  out  1  restore the correct PC after a misprediction.

Function
REQ-020 Each register r>0 SHALL hold cnt[r] of LAT_W bits; cnt[0] SHALL read 0 always.
REQ-021 mispredict = br_resolve & (br_taken ^ br_pred); cpc = mispredict; flush = mispredict | jump (combinational).
REQ-022 Source hazard: a used source s>0 SHALL stall when cnt[s] > BR_PEN for a non-branch, or cnt[s] != 0 for a branch.
REQ-023 stall = id_valid & (any source hazard | ex_hold) & !flush.
REQ-024 issue = id_valid & !stall & !flush.
REQ-025 On issue with id_wr and id_dst!=0, cnt[id_dst] SHALL load UNK if id_lat==UNK, else min(id_lat+BR_PEN, UNK-1).
REQ-026 Every cycle with ex_hold=0, each cnt not equal to 0 or UNK and not being loaded SHALL decrement by 1.
REQ-027 With ex_hold=1, all counters SHALL hold, except wb_done clears.
REQ-028 wb_done with wb_dst!=0 SHALL clear cnt[wb_dst] to 0 whatever its value.
REQ-029 A load to the same register in the same cycle SHALL win over a wb_done clear or a decrement.
REQ-030 A flush cycle SHALL NOT load any counter; existing counters SHALL continue per REQ-026/027.
REQ-031 Sources equal to register 0 or with use_*=0 SHALL never cause a stall.

Reset
REQ-032 While rst=1, all cnt SHALL be 0, stall, issue, flush and cpc SHALL be 0 (flush/cpc gated by rst), and any perf counters SHALL be 0.
REQ-033 Deasserting rst mid-flight SHALL yield an empty scoreboard; no pending write survives.

Configuration
REQ-034 Macro HAZARD_PERF_CNT_EN defined: add outputs perf_stall_cyc (32b, counts cycles with stall=1 and ex_hold=0) and perf_flush_cnt (32b, counts flush cycles), both saturating at all-ones.
REQ-035 Macro undefined: those ports and their logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-036 Package hazard_pkg SHALL hold LAT_W default, the UNK localparam, BR_PEN default and the mispredict helper function.
REQ-037 Per-register counter SHALL be sub-module hz_sb_entry (load, clear, hold, decrement, UNK sticky), instantiated NUM_REGS-1 times.

Verification
REQ-038 Issue lw (id_lat=1, dst=8), next add reads r8 -> stall=1 for exactly 1 cycle (cnt 2->1), then issue=1.
REQ-039 Issue lw dst=8, next beq reads r8 with BR_PEN=1 -> stall 2 cycles, issue on the 3rd.
REQ-040 Issue div (id_lat=7 UNK, dst=9), consumer of r9 -> stall until wb_done, wb_dst=9; issue in the following cycle.
REQ-041 br_resolve=1, br_taken=1, br_pred=0 while ID holds a writer of r5 -> flush=1, cpc=1, issue=0, cnt[5] stays 0.
REQ-042 ex_hold=1 for 3 cycles with cnt[8]=2 -> cnt[8] remains 2; stall=1 throughout; resumes decrement after.
REQ-043 Same cycle: issue writer to r9 (id_lat=2) and wb_done wb_dst=9 -> cnt[9]=3; assert rst mid-stall -> all outputs 0 immediately.
